vga_timing_generator: RTL and testbench
=======================================

Name: vga_timing_generator

Overview:
Parametrised VGA raster engine that replaces the fixed-mode timing logic inside the GPU core. It generates hsync/vsync, pixel coordinates and a pixel-request strobe for the framebuffer/renderer. It re-aligns the returned colour data against sync/blank through a configurable latency pipeline, and has a built-in colour-bar test pattern mode. It sits in the vga_clock domain between the pixel source and the board-level RGB pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width
H_BACK, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch
HSYNC_ACTIVE, 0, hsync asserted level
VSYNC_ACTIVE, 0, vsync asserted level
VGA_RED_BITS, 3, red width
VGA_GREEN_BITS, 3, green width
VGA_BLUE_BITS, 2, blue width
X_BITS, 10, pixel_x / h counter width (must hold H_TOTAL-1)
Y_BITS, 10, pixel_y / v counter width (must hold V_TOTAL-1)
FETCH_LATENCY, 2, clocks from pixel_request to valid pixel_* data (1..8)

Ports:
vga_clock  input  1  pixel clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  run raster; low = hold in idle
test_pattern  input  1  1 = output internal colour bars, ignore pixel_* inputs
pixel_red  input  VGA_RED_BITS  requested pixel colour, valid FETCH_LATENCY clocks after request
pixel_green  input  VGA_GREEN_BITS  as above
pixel_blue  input  VGA_BLUE_BITS  as above
pixel_request  output  1  high when (pixel_x,pixel_y) is a visible pixel
pixel_x  output  X_BITS  current h counter
pixel_y  output  Y_BITS  current v counter
frame_start  output  1  one-clock pulse at h=0,v=0
line_start  output  1  one-clock pulse at h=0 of every line
vga_hsync  output  1  horizontal sync, aligned to colour outputs
vga_vsync  output  1  vertical sync, aligned to colour outputs
vga_red  output  VGA_RED_BITS  registered colour, 0 in blanking
vga_green  output  VGA_GREEN_BITS  as above
vga_blue  output  VGA_BLUE_BITS  as above
in_vblank  output  1  high while delayed v position >= V_ACTIVE

Behaviour:
- Reset is async on reset_n low. h=v=0; all delay stages cleared; pixel_request/frame_start/line_start=0; vga_hsync=!HSYNC_ACTIVE; vga_vsync=!VSYNC_ACTIVE; colours 0; in_vblank=0.
- H_TOTAL=H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- enable low: counters forced to 0 synchronously. Requests and pulses are 0. Delay pipeline flushes to inactive sync / zero colour. Scan restarts at (0,0) on the first clock with enable high, with frame_start high in that clock.
- Counting: h increments every clock and wraps at H_TOTAL-1 -> 0. v increments only on h wrap and wraps at V_TOTAL-1 -> 0.
- Stage 0, combinational from the counters: pixel_x=h, pixel_y=v; pixel_request=(h<H_ACTIVE)&&(v<V_ACTIVE).
- Raw hsync active for h in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1]. Raw vsync active for v in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1]. vsync changes at the h wrap.
- Alignment: raw hsync, vsync, visible flag and vblank are shifted through FETCH_LATENCY stages, then registered once more. pixel_* is sampled exactly FETCH_LATENCY clocks after its request. The vga_* outputs therefore appear FETCH_LATENCY+1 clocks after the matching stage-0 counter value.
- Colour output = delayed visible ? source : 0.
- Test pattern: 8 vertical bars, each H_ACTIVE/8 wide (integer; a remainder is added to the last bar). Bar index k comes from a bar counter that resets at h=0 and steps every H_ACTIVE/8 pixels; no divider. Bar k colour: red all-ones if k[2], green all-ones if k[1], blue all-ones if k[0]. Bar colour is generated at stage 0 and delayed identically to the source path.
- test_pattern may change at any time. The new source takes effect for pixels requested from the next clock; no glitch on sync.
- Simultaneous h and v wrap: both go to 0 in the same clock, and frame_start and line_start both pulse.

Test Plan:
- Small timing (H 16/2/3/3 -> H_TOTAL 24; V 4/1/2/1 -> V_TOTAL 8; FETCH_LATENCY 2), release reset -> frame_start at clock 0 and every 192 clocks; line_start every 24 clocks; pixel_request high for h 0..15 on v 0..3 only.
- Same config, check output sync -> vga_hsync low (HSYNC_ACTIVE=0) for exactly 3 clocks, starting 21 clocks after line_start; vga_vsync low for exactly 48 clocks, starting 3 clocks after the stage-0 v=5 begins.
- Latency check: drive pixel_red = pixel_x[2:0] delayed 2 clocks -> vga_red equals 0,1,..,7,0.. starting 3 clocks after line_start; vga_red=0 for all of h 16..23 and lines 4..7.
- test_pattern=1 with H_ACTIVE=16 -> 2-pixel bars. Output sequence (R,G,B) is (0,0,0),(0,0,3),(0,7,0),(0,7,3),(7,0,0),(7,0,3),(7,7,0),(7,7,3) with VGA_BLUE_BITS=2, each for 2 clocks.
- Assert reset_n low mid-line at h=10,v=2 -> outputs go to reset values immediately, asynchronously. After release, frame_start occurs on the first clock.
- Drop enable for 5 clocks mid-frame -> syncs inactive and colours 0 after the pipeline drains (3 clocks). On re-enable, frame_start pulses in the first enabled clock, and first visible colour appears 3 clocks later.

Source files
------------

// File: rtl/vga_timing_generator.sv
// rtl/vga_timing_generator.sv - parametrised VGA raster engine with fetch-latency alignment and colour bars
module vga_timing_generator #(
    parameter int H_ACTIVE       = 640,
    parameter int H_FRONT        = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BACK         = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FRONT        = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BACK         = 33,
    parameter int HSYNC_ACTIVE   = 0,
    parameter int VSYNC_ACTIVE   = 0,
    parameter int VGA_RED_BITS   = 3,
    parameter int VGA_GREEN_BITS = 3,
    parameter int VGA_BLUE_BITS  = 2,
    parameter int X_BITS         = 10,
    parameter int Y_BITS         = 10,
    parameter int FETCH_LATENCY  = 2
) (
    input  logic                      vga_clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      test_pattern,
    input  logic [VGA_RED_BITS-1:0]   pixel_red,
    input  logic [VGA_GREEN_BITS-1:0] pixel_green,
    input  logic [VGA_BLUE_BITS-1:0]  pixel_blue,
    output logic                      pixel_request,
    output logic [X_BITS-1:0]         pixel_x,
    output logic [Y_BITS-1:0]         pixel_y,
    output logic                      frame_start,
    output logic                      line_start,
    output logic                      vga_hsync,
    output logic                      vga_vsync,
    output logic [VGA_RED_BITS-1:0]   vga_red,
    output logic [VGA_GREEN_BITS-1:0] vga_green,
    output logic [VGA_BLUE_BITS-1:0]  vga_blue,
    output logic                      in_vblank
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [X_BITS-1:0] H_LAST     = X_BITS'(H_TOTAL - 1);
    localparam logic [X_BITS-1:0] H_ACT      = X_BITS'(H_ACTIVE);
    localparam logic [X_BITS-1:0] HS_FIRST   = X_BITS'(H_ACTIVE + H_FRONT);
    localparam logic [X_BITS-1:0] HS_LAST    = X_BITS'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [X_BITS-1:0] BAR_W_LAST = X_BITS'(H_ACTIVE / 8 - 1);
    localparam logic [Y_BITS-1:0] V_LAST     = Y_BITS'(V_TOTAL - 1);
    localparam logic [Y_BITS-1:0] V_ACT      = Y_BITS'(V_ACTIVE);
    localparam logic [Y_BITS-1:0] VS_FIRST   = Y_BITS'(V_ACTIVE + V_FRONT);
    localparam logic [Y_BITS-1:0] VS_LAST    = Y_BITS'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    localparam logic HS_ON = (HSYNC_ACTIVE != 0);
    localparam logic VS_ON = (VSYNC_ACTIVE != 0);

    typedef struct packed {
        logic       vis;
        logic       hs;
        logic       vs;
        logic       vb;
        logic       tp;
        logic [2:0] bar;
    } stage_t;

    logic [X_BITS-1:0] h_q, h_d;
    logic [Y_BITS-1:0] v_q, v_d;
    logic [X_BITS-1:0] bar_pos_q, bar_pos_d;
    logic [2:0]        bar_idx_q, bar_idx_d;
    logic              tp_q;
    logic              h_wrap, v_wrap, run;
    stage_t            raw;
    stage_t            pipe_q [FETCH_LATENCY];
    stage_t            last;

    logic                      hsync_q, vsync_q, vblank_q;
    logic [VGA_RED_BITS-1:0]   red_q;
    logic [VGA_GREEN_BITS-1:0] green_q;
    logic [VGA_BLUE_BITS-1:0]  blue_q;

    always_comb begin
        h_wrap = (h_q == H_LAST);
        v_wrap = (v_q == V_LAST);
        h_d    = h_q;
        v_d    = v_q;
        if (!enable) begin
            h_d = '0;
            v_d = '0;
        end else begin
            h_d = h_wrap ? '0 : h_q + 1'b1;
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + 1'b1;
            end
        end
    end

    // Bar index tracks h with a pixel-in-bar counter; the last bar absorbs any remainder.
    always_comb begin
        bar_pos_d = bar_pos_q;
        bar_idx_d = bar_idx_q;
        if (h_d == '0) begin
            bar_pos_d = '0;
            bar_idx_d = '0;
        end else if (bar_idx_q != 3'd7) begin
            if (bar_pos_q == BAR_W_LAST) begin
                bar_pos_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_pos_d = bar_pos_q + 1'b1;
            end
        end
    end

    // Stage-0 strobes are gated by reset_n so they drop the moment reset asserts.
    always_comb begin
        run     = reset_n & enable;
        raw.vis = run && (h_q < H_ACT) && (v_q < V_ACT);
        raw.hs  = run && (h_q >= HS_FIRST) && (h_q <= HS_LAST);
        raw.vs  = run && (v_q >= VS_FIRST) && (v_q <= VS_LAST);
        raw.vb  = run && (v_q >= V_ACT);
        raw.tp  = tp_q;
        raw.bar = bar_idx_q;
    end

    assign pixel_x       = h_q;
    assign pixel_y       = v_q;
    assign pixel_request = raw.vis;
    assign frame_start   = run && (h_q == '0) && (v_q == '0);
    assign line_start    = run && (h_q == '0);

    always_ff @(posedge vga_clock or negedge reset_n) begin
        if (!reset_n) begin
            h_q       <= '0;
            v_q       <= '0;
            bar_pos_q <= '0;
            bar_idx_q <= '0;
            tp_q      <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            bar_pos_q <= bar_pos_d;
            bar_idx_q <= bar_idx_d;
            tp_q      <= test_pattern;
        end
    end

    always_ff @(posedge vga_clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FETCH_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= raw;
            for (int i = 1; i < FETCH_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign last = pipe_q[FETCH_LATENCY-1];

    // Final register: pixel_* arrives in the same clock the request leaves the delay line.
    always_ff @(posedge vga_clock or negedge reset_n) begin
        if (!reset_n) begin
            hsync_q  <= ~HS_ON;
            vsync_q  <= ~VS_ON;
            vblank_q <= 1'b0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
        end else begin
            hsync_q  <= last.hs ? HS_ON : ~HS_ON;
            vsync_q  <= last.vs ? VS_ON : ~VS_ON;
            vblank_q <= last.vb;
            if (!last.vis) begin
                red_q   <= '0;
                green_q <= '0;
                blue_q  <= '0;
            end else if (last.tp) begin
                red_q   <= {VGA_RED_BITS{last.bar[2]}};
                green_q <= {VGA_GREEN_BITS{last.bar[1]}};
                blue_q  <= {VGA_BLUE_BITS{last.bar[0]}};
            end else begin
                red_q   <= pixel_red;
                green_q <= pixel_green;
                blue_q  <= pixel_blue;
            end
        end
    end

    assign vga_hsync = hsync_q;
    assign vga_vsync = vsync_q;
    assign in_vblank = vblank_q;
    assign vga_red   = red_q;
    assign vga_green = green_q;
    assign vga_blue  = blue_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// tb/tb_vga_timing_generator.sv - scoreboard bench for vga_timing_generator on a small raster
module tb_vga_timing_generator;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       test_pattern = 1'b0;
    logic [2:0] pixel_red = '0;
    logic [2:0] pixel_green = '0;
    logic [1:0] pixel_blue = '0;
    logic       pixel_request, frame_start, line_start;
    logic [5:0] pixel_x;
    logic [3:0] pixel_y;
    logic       vga_hsync, vga_vsync, in_vblank;
    logic [2:0] vga_red, vga_green;
    logic [1:0] vga_blue;

    vga_timing_generator #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_ACTIVE(0), .VSYNC_ACTIVE(0),
        .VGA_RED_BITS(3), .VGA_GREEN_BITS(3), .VGA_BLUE_BITS(2),
        .X_BITS(6), .Y_BITS(4), .FETCH_LATENCY(LAT)
    ) dut (
        .vga_clock(clk), .reset_n(reset_n), .enable(enable), .test_pattern(test_pattern),
        .pixel_red(pixel_red), .pixel_green(pixel_green), .pixel_blue(pixel_blue),
        .pixel_request(pixel_request), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .frame_start(frame_start), .line_start(line_start),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .in_vblank(in_vblank)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit vis, hs, vs, vb, tp;
        int k;
    } rec_t;

    typedef struct {
        int px, py;
        bit req, fs, ls, hs, vs, vb;
        int r, g, b;
    } exp_t;

    exp_t exp_q[$];
    rec_t hist[$];
    int   checks = 0;
    int   errors = 0;
    int   n = 0;
    bit   tp_prev = 0;
    int   pr_prev = 0, pg_prev = 0, pb_prev = 0;

    function automatic rec_t make_rec(int pos, bit en, bit tp);
        rec_t r;
        int h = pos % HT;
        int v = pos / HT;
        r.vis = en && h < HA && v < VA;
        r.hs  = en && h >= HA + HF && h < HA + HF + HS;
        r.vs  = en && v >= VA + VF && v < VA + VF + VS;
        r.vb  = en && v >= VA;
        r.tp  = tp;
        r.k   = (h / (HA / 8) > 7) ? 7 : h / (HA / 8);
        return r;
    endfunction

    function automatic rec_t idle_rec();
        rec_t r;
        r.vis = 0; r.hs = 0; r.vs = 0; r.vb = 0; r.tp = 0; r.k = 0;
        return r;
    endfunction

    task automatic step(input bit rst, input bit en, input bit tp);
        exp_t e;
        rec_t o;
        int   h, v, nr, ng, nb;
        @(posedge clk);
        #1;
        nr = $urandom_range(0, 7);
        ng = $urandom_range(0, 7);
        nb = $urandom_range(0, 3);
        reset_n = !rst;
        enable = en;
        test_pattern = tp;
        pixel_red = 3'(nr);
        pixel_green = 3'(ng);
        pixel_blue = 2'(nb);
        if (rst) begin
            e.px = 0; e.py = 0; e.req = 0; e.fs = 0; e.ls = 0;
            e.hs = 1; e.vs = 1; e.vb = 0; e.r = 0; e.g = 0; e.b = 0;
            exp_q.push_back(e);
            n = 0;
            tp_prev = 0;
            hist.delete();
            for (int i = 0; i <= LAT; i++) hist.push_back(idle_rec());
        end else begin
            h = n % HT;
            v = n / HT;
            e.px = h; e.py = v;
            e.req = en && h < HA && v < VA;
            e.fs = en && h == 0 && v == 0;
            e.ls = en && h == 0;
            hist.push_back(make_rec(n, en, tp_prev));
            o = hist.pop_front();
            e.hs = !o.hs;
            e.vs = !o.vs;
            e.vb = o.vb;
            if (!o.vis) begin
                e.r = 0; e.g = 0; e.b = 0;
            end else if (o.tp) begin
                e.r = (o.k & 4) ? 7 : 0;
                e.g = (o.k & 2) ? 7 : 0;
                e.b = (o.k & 1) ? 3 : 0;
            end else begin
                e.r = pr_prev; e.g = pg_prev; e.b = pb_prev;
            end
            exp_q.push_back(e);
            n = en ? (n + 1) % (HT * VT) : 0;
            tp_prev = tp;
        end
        pr_prev = nr; pg_prev = ng; pb_prev = nb;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pixel_x", 32'(pixel_x), e.px);
                chk("pixel_y", 32'(pixel_y), e.py);
                chk("pixel_request", 32'(pixel_request), 32'(e.req));
                chk("frame_start", 32'(frame_start), 32'(e.fs));
                chk("line_start", 32'(line_start), 32'(e.ls));
                chk("vga_hsync", 32'(vga_hsync), 32'(e.hs));
                chk("vga_vsync", 32'(vga_vsync), 32'(e.vs));
                chk("in_vblank", 32'(in_vblank), 32'(e.vb));
                chk("vga_red", 32'(vga_red), e.r);
                chk("vga_green", 32'(vga_green), e.g);
                chk("vga_blue", 32'(vga_blue), e.b);
            end
        end
    end

    initial begin : driver
        bit tp = 0;
        int guard;
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        for (int i = 0; i < 2 * HT * VT; i++) step(0, 1, 0);
        for (int i = 0; i < HT * VT; i++) step(0, 1, 1);
        for (int i = 0; i < HT * VT; i++) step(0, 1, (i % 37) < 20);
        guard = 0;
        while (n != 2 * HT + 10 && guard < 2 * HT * VT) begin
            step(0, 1, 0);
            guard++;
        end
        chk("reach_h10_v2", 32'(n), 2 * HT + 10);
        for (int i = 0; i < 2; i++) step(1, 1, 0);
        for (int i = 0; i < HT * VT; i++) step(0, 1, 0);
        for (int i = 0; i < 30; i++) step(0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        for (int i = 0; i < HT * VT; i++) step(0, 1, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) tp = !tp;
            if ($urandom_range(0, 999) < 3) step(1, 1, tp);
            else step(0, $urandom_range(0, 99) < 96, tp);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
